// File: rtl/swap_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : swap_scheduler
// Description : Two-requester round-robin register-swap engine with a small
//               register file, direct load port and combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module swap_scheduler #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [AW-1:0] req0_idx_a,
    input  logic [AW-1:0] req0_idx_b,
    input  logic [AW-1:0] req1_idx_a,
    input  logic [AW-1:0] req1_idx_b,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic [7:0]    swap_count
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LATCH = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;

    logic [1:0]    r_state;
    logic [DW-1:0] r_regs [NREG];
    logic [DW-1:0] r_tmp_a;
    logic [DW-1:0] r_tmp_b;
    logic [AW-1:0] r_idx_a;
    logic [AW-1:0] r_idx_b;
    logic          r_id;
    logic          r_last_grant;
    logic          r_done;
    logic          r_done_id;
    logic [7:0]    r_swap_count;

    logic [1:0]    w_grant;
    logic          w_handshake;
    logic          w_sel;

    // Grants are only offered in IDLE and never while reset is held.
    always_comb begin
        w_grant = 2'b00;
        if (rst_n && (r_state == c_IDLE)) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_handshake = |(req_valid & w_grant);
    assign w_sel       = w_grant[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_tmp_a      <= '0;
            r_tmp_b      <= '0;
            r_idx_a      <= '0;
            r_idx_b      <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_done       <= 1'b0;
            r_done_id    <= 1'b0;
            r_swap_count <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (wr_en) begin
                        r_regs[wr_idx] <= wr_data;
                    end
                    if (w_handshake) begin
                        r_idx_a      <= w_sel ? req1_idx_a : req0_idx_a;
                        r_idx_b      <= w_sel ? req1_idx_b : req0_idx_b;
                        r_id         <= w_sel;
                        r_last_grant <= w_sel;
                        r_state      <= c_LATCH;
                    end
                end
                c_LATCH: begin
                    r_tmp_a <= r_regs[r_idx_a];
                    r_tmp_b <= r_regs[r_idx_b];
                    r_state <= c_WRITE;
                end
                c_WRITE: begin
                    // With equal indices the second write restores the original value.
                    r_regs[r_idx_a] <= r_tmp_b;
                    r_regs[r_idx_b] <= r_tmp_a;
                    r_done          <= 1'b1;
                    r_done_id       <= r_id;
                    r_swap_count    <= r_swap_count + 8'd1;
                    r_state         <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_grant;
    assign rd_data    = r_regs[rd_idx];
    assign busy       = (r_state != c_IDLE);
    assign done       = r_done;
    assign done_id    = r_done_id;
    assign swap_count = r_swap_count;

endmodule
`default_nettype wire

// File: tb/tb_swap_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_swap_scheduler
// Description : Self-checking bench for swap_scheduler: directed scenarios plus
//               randomized traffic against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_swap_scheduler;

    localparam int DW   = 8;
    localparam int NREG = 4;
    localparam int AW   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [AW-1:0] req0_idx_a, req0_idx_b, req1_idx_a, req1_idx_b;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] rd_data;
    logic          busy, done, done_id;
    logic [7:0]    swap_count;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: register contents, completed-swap count, last winner.
    logic [7:0] m_regs [NREG];
    int         m_count;
    logic       m_last;

    always #10 clk = ~clk;

    swap_scheduler #(.DW(DW), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_idx_a(req0_idx_a), .req0_idx_b(req0_idx_b),
        .req1_idx_a(req1_idx_a), .req1_idx_b(req1_idx_b),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .busy(busy), .done(done), .done_id(done_id), .swap_count(swap_count)
    );

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return (m_last == 1'b1) ? 0 : 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_count = 0;
        m_last  = 1'b1;
    endtask

    task automatic drive_idle();
        req_valid = 2'b00;
        req0_idx_a = '0; req0_idx_b = '0; req1_idx_a = '0; req1_idx_b = '0;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [AW-1:0] idx, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_idx = idx; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [AW-1:0] idx, output logic [DW-1:0] d);
        rd_idx = idx;
        #1;
        d = rd_data;
    endtask

    // Handshake one requester from IDLE and stop at the negedge where done is due.
    task automatic do_handshake(input logic id, input logic [AW-1:0] a, input logic [AW-1:0] b);
        if (id) begin req1_idx_a = a; req1_idx_b = b; req_valid = 2'b10; end
        else    begin req0_idx_a = a; req0_idx_b = b; req_valid = 2'b01; end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        drive_idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        req_valid = 2'b11;
        #2;
        if (req_ready !== 2'b00) $display("FAIL rst_ready: got %b expected 00", req_ready); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_total++;
        if (done !== 1'b0 || done_id !== 1'b0) $display("FAIL rst_done: got %b/%b expected 0/0", done, done_id); else n_pass++;
        n_total++;
        if (swap_count !== 8'd0) $display("FAIL rst_count: got %0d expected 0", swap_count); else n_pass++;
        n_total++;
        for (int i = 0; i < NREG; i++) begin
            read_reg(i[AW-1:0], d);
            if (d !== 8'h00) $display("FAIL rst_reg%0d: got %h expected 00", i, d); else n_pass++;
            n_total++;
        end
        @(negedge clk);
        if (busy !== 1'b0) $display("FAIL rst_hold_busy: got %b expected 0", busy); else n_pass++;
        n_total++;
        rst_n = 1'b1;
        #1;
        if (req_ready !== 2'b01) $display("FAIL rst_first_tie: got %b expected 01", req_ready); else n_pass++;
        n_total++;
        @(negedge clk);
        req_valid = 2'b00;
        if (busy !== 1'b1) $display("FAIL rst_first_edge: busy got %b expected 1", busy); else n_pass++;
        n_total++;
        @(negedge clk);
        @(negedge clk);
        if (done !== 1'b1 || done_id !== 1'b0) $display("FAIL rst_first_done: got %b/%b expected 1/0", done, done_id); else n_pass++;
        n_total++;
    endtask

    task automatic test_basic_swap();
        logic [DW-1:0] d0, d1;
        hard_reset();
        load(2'd0, 8'hAA);
        load(2'd1, 8'h55);
        req0_idx_a = 2'd0; req0_idx_b = 2'd1; req_valid = 2'b01;
        #1;
        if (req_ready !== 2'b01) $display("FAIL basic_ready: got %b expected 01", req_ready); else n_pass++;
        n_total++;
        @(negedge clk);
        req0_idx_a = 2'd3; req0_idx_b = 2'd2;
        #1;
        if (busy !== 1'b1 || req_ready !== 2'b00) $display("FAIL basic_latch: busy/ready got %b/%b expected 1/00", busy, req_ready); else n_pass++;
        n_total++;
        @(negedge clk);
        req_valid = 2'b00;
        read_reg(2'd0, d0);
        if (done !== 1'b0 || d0 !== 8'hAA) $display("FAIL basic_write_phase: done/r0 got %b/%h expected 0/aa", done, d0); else n_pass++;
        n_total++;
        @(negedge clk);
        read_reg(2'd0, d0);
        read_reg(2'd1, d1);
        if (d0 !== 8'h55 || d1 !== 8'hAA) $display("FAIL basic_regs: got r0=%h r1=%h expected 55/aa", d0, d1); else n_pass++;
        n_total++;
        if (done !== 1'b1 || done_id !== 1'b0 || swap_count !== 8'd1)
            $display("FAIL basic_done: got done=%b id=%b cnt=%0d expected 1/0/1", done, done_id, swap_count);
        else n_pass++;
        n_total++;
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_pulse: done/busy got %b/%b expected 0/0", done, busy); else n_pass++;
        n_total++;
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] d2, d3;
        hard_reset();
        load(2'd0, 8'h01);
        load(2'd1, 8'h02);
        load(2'd2, 8'h11);
        load(2'd3, 8'h22);
        req0_idx_a = 2'd0; req0_idx_b = 2'd1;
        req1_idx_a = 2'd2; req1_idx_b = 2'd3;
        req_valid = 2'b11;
        #1;
        if (req_ready !== 2'b01) $display("FAIL rr_first: got %b expected 01", req_ready); else n_pass++;
        n_total++;
        repeat (3) @(negedge clk);
        #1;
        if (done !== 1'b1 || done_id !== 1'b0) $display("FAIL rr_done0: got %b/%b expected 1/0", done, done_id); else n_pass++;
        n_total++;
        if (req_ready !== 2'b10) $display("FAIL rr_second: got %b expected 10", req_ready); else n_pass++;
        n_total++;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        read_reg(2'd2, d2);
        read_reg(2'd3, d3);
        if (done !== 1'b1 || done_id !== 1'b1) $display("FAIL rr_done1: got %b/%b expected 1/1", done, done_id); else n_pass++;
        n_total++;
        if (d2 !== 8'h22 || d3 !== 8'h11) $display("FAIL rr_regs: got r2=%h r3=%h expected 22/11", d2, d3); else n_pass++;
        n_total++;
    endtask

    task automatic test_no_starvation();
        logic [1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};
        hard_reset();
        req0_idx_a = 2'd0; req0_idx_b = 2'd1;
        req1_idx_a = 2'd2; req1_idx_b = 2'd3;
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (req_ready !== exp_g[k]) $display("FAIL starve_grant%0d: got %b expected %b", k, req_ready, exp_g[k]); else n_pass++;
            n_total++;
            @(negedge clk);
            if (k == 1) req_valid = 2'b01;
            repeat (2) @(negedge clk);
            if (done !== 1'b1 || done_id !== exp_g[k][1])
                $display("FAIL starve_done%0d: got %b/%b expected 1/%b", k, done, done_id, exp_g[k][1]);
            else n_pass++;
            n_total++;
            if (k == 0) req_valid = 2'b11;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_same_idx();
        logic [DW-1:0] d;
        hard_reset();
        load(2'd2, 8'h3C);
        do_handshake(1'b1, 2'd2, 2'd2);
        read_reg(2'd2, d);
        if (d !== 8'h3C) $display("FAIL same_reg: got %h expected 3c", d); else n_pass++;
        n_total++;
        if (done !== 1'b1 || done_id !== 1'b1 || swap_count !== 8'd1)
            $display("FAIL same_done: got done=%b id=%b cnt=%0d expected 1/1/1", done, done_id, swap_count);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_write_busy();
        logic [DW-1:0] d0, d1, d3;
        hard_reset();
        load(2'd0, 8'h12);
        load(2'd1, 8'h34);
        req0_idx_a = 2'd0; req0_idx_b = 2'd1; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        wr_en = 1'b1; wr_idx = 2'd1; wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        read_reg(2'd0, d0);
        read_reg(2'd1, d1);
        if (d0 !== 8'h34 || d1 !== 8'h12) $display("FAIL busy_write: got r0=%h r1=%h expected 34/12", d0, d1); else n_pass++;
        n_total++;
        // load and handshake on the same edge: swap must see the loaded value
        wr_en = 1'b1; wr_idx = 2'd3; wr_data = 8'h77;
        req0_idx_a = 2'd3; req0_idx_b = 2'd0; req_valid = 2'b01;
        @(negedge clk);
        wr_en = 1'b0; req_valid = 2'b00;
        repeat (2) @(negedge clk);
        read_reg(2'd0, d0);
        read_reg(2'd3, d3);
        if (d0 !== 8'h77 || d3 !== 8'h34) $display("FAIL load_and_swap: got r0=%h r3=%h expected 77/34", d0, d3); else n_pass++;
        n_total++;
    endtask

    task automatic test_reset_abort();
        logic [DW-1:0] d;
        int pulses = 0;
        req0_idx_a = 2'd0; req0_idx_b = 2'd1; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #2 rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        if (busy !== 1'b0 || req_ready !== 2'b00) $display("FAIL abort_state: busy/ready got %b/%b expected 0/00", busy, req_ready); else n_pass++;
        n_total++;
        if (swap_count !== 8'd0) $display("FAIL abort_count: got %0d expected 0", swap_count); else n_pass++;
        n_total++;
        for (int i = 0; i < NREG; i++) begin
            read_reg(i[AW-1:0], d);
            if (d !== 8'h00) $display("FAIL abort_reg%0d: got %h expected 00", i, d); else n_pass++;
            n_total++;
        end
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) pulses++;
        end
        if (pulses != 0) $display("FAIL abort_done: got %0d pulses expected 0", pulses); else n_pass++;
        n_total++;
        rst_n = 1'b1;
        #1;
        if (req_ready !== 2'b01) $display("FAIL abort_rearm: got %b expected 01", req_ready); else n_pass++;
        n_total++;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0]    v;
        logic [1:0]    exp_ready;
        logic [AW-1:0] ca, cb;
        logic [DW-1:0] ta, d;
        int            g;
        int            errs;
        hard_reset();
        model_reset();
        for (int it = 0; it < 300; it++) begin
            v = 2'($urandom_range(0, 3));
            req_valid  = v;
            req0_idx_a = AW'($urandom); req0_idx_b = AW'($urandom);
            req1_idx_a = AW'($urandom); req1_idx_b = AW'($urandom);
            wr_en = 1'($urandom); wr_idx = AW'($urandom); wr_data = DW'($urandom);
            #1;
            g = pick(v);
            exp_ready = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
            if (req_ready !== exp_ready) $display("FAIL rand_ready it%0d: got %b expected %b", it, req_ready, exp_ready); else n_pass++;
            n_total++;
            if (wr_en) m_regs[wr_idx] = wr_data;
            if (g >= 0) begin
                ca = (g == 1) ? req1_idx_a : req0_idx_a;
                cb = (g == 1) ? req1_idx_b : req0_idx_b;
                repeat (2) begin
                    @(negedge clk);
                    req_valid  = 2'($urandom);
                    req0_idx_a = AW'($urandom); req0_idx_b = AW'($urandom);
                    req1_idx_a = AW'($urandom); req1_idx_b = AW'($urandom);
                    wr_en = 1'($urandom); wr_idx = AW'($urandom); wr_data = DW'($urandom);
                    rd_idx = AW'($urandom);
                    #1;
                    if (req_ready !== 2'b00 || busy !== 1'b1 || rd_data !== m_regs[rd_idx])
                        $display("FAIL rand_busy it%0d: ready=%b busy=%b rd=%h expected 00/1/%h", it, req_ready, busy, rd_data, m_regs[rd_idx]);
                    else n_pass++;
                    n_total++;
                end
                @(negedge clk);
                wr_en = 1'b0;
                ta = m_regs[ca];
                m_regs[ca] = m_regs[cb];
                m_regs[cb] = ta;
                m_count = (m_count + 1) % 256;
                m_last = g[0];
                if (done !== 1'b1 || done_id !== g[0] || swap_count !== m_count[7:0])
                    $display("FAIL rand_done it%0d: done=%b id=%b cnt=%0d expected 1/%0d/%0d", it, done, done_id, swap_count, g, m_count);
                else n_pass++;
                n_total++;
                errs = 0;
                for (int i = 0; i < NREG; i++) begin
                    read_reg(i[AW-1:0], d);
                    if (d !== m_regs[i]) errs++;
                end
                if (errs != 0) $display("FAIL rand_regs it%0d: got %0d wrong registers expected 0", it, errs); else n_pass++;
                n_total++;
            end else begin
                @(negedge clk);
                wr_en = 1'b0;
                rd_idx = AW'($urandom);
                #1;
                if (done !== 1'b0 || busy !== 1'b0 || rd_data !== m_regs[rd_idx])
                    $display("FAIL rand_idle it%0d: done=%b busy=%b rd=%h expected 0/0/%h", it, done, busy, rd_data, m_regs[rd_idx]);
                else n_pass++;
                n_total++;
            end
        end
        drive_idle();
    endtask

    task automatic test_back_to_back_wrap();
        int pulses = 0;
        hard_reset();
        req0_idx_a = 2'd0; req0_idx_b = 2'd1; req_valid = 2'b01;
        for (int k = 0; k < 256; k++) begin
            repeat (3) begin
                @(negedge clk);
                if (done === 1'b1) pulses++;
            end
            if (k == 254) begin
                if (swap_count !== 8'd255) $display("FAIL wrap_255: got %0d expected 255", swap_count); else n_pass++;
                n_total++;
            end
        end
        req_valid = 2'b00;
        if (swap_count !== 8'd0) $display("FAIL wrap_zero: got %0d expected 0", swap_count); else n_pass++;
        n_total++;
        if (pulses != 256) $display("FAIL wrap_throughput: got %0d done pulses expected 256", pulses); else n_pass++;
        n_total++;
    endtask

    initial begin
        test_reset();
        test_basic_swap();
        test_round_robin();
        test_no_starvation();
        test_same_idx();
        test_write_busy();
        test_reset_abort();
        test_random();
        test_back_to_back_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
